input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Parametrised multi-channel conditioner for the game's raw board inputs (START button, SW[15:0] switches, future jump/duck keys).
- Per channel: input polarity normalisation, 2-flop synchroniser, counter-based debouncer, registered rise/fall edge pulses.
- Sits between the board pins and the game FSM inside Top. The FSM consumes only clean levels and single-cycle pulses, never raw pins.

Parameters:
- NUM_CH, 16, number of independent channels (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced level changes (>=1; bench uses 4).
- INVERT_MASK, 0, per-channel NUM_CH-bit mask; bit i=1 means raw input i is active-low and is inverted before the synchroniser.
- REPEAT_DELAY, 25000000, cycles from rise to first auto-repeat pulse (used only with AUTO_REPEAT_EN; >=1).
- REPEAT_PERIOD, 5000000, cycles between later auto-repeat pulses (used only with AUTO_REPEAT_EN; >=1).

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-low reset
- raw_in  input  NUM_CH  unsynchronised pin levels
- level  output  NUM_CH  debounced, polarity-normalised level
- rise  output  NUM_CH  one-cycle pulse on debounced 0->1 (and auto-repeat pulses)
- fall  output  NUM_CH  one-cycle pulse on debounced 1->0
- any_rise  output  1  OR-reduction of rise, registered together with rise

Behaviour:
- Reset (RESET=0, asynchronous): sync flops, level, rise, fall, any_rise, all counters = 0.
  - Channels with INVERT_MASK=1 also start at level 0, i.e. "released".
  - Deassertion takes effect on the next CLK rising edge.
- Per channel i, every CLK edge:
  - n = raw_in[i] ^ INVERT_MASK[i].
  - s1 <= n; s2 <= s1.
- Debounce, per channel:
  - If s2 == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= s2, cnt <= 0.
  - Else cnt <= cnt+1.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). Counter never wraps.
- Latency: raw change first sampled at edge E -> level changes at edge E+1+DEBOUNCE_CYCLES.
- Glitch rejection: any cycle with s2 == level restarts the count. A bounce shorter than DEBOUNCE_CYCLES cycles never changes level.
- Edge pulses:
  - rise[i]/fall[i] are registered and go high at the same edge level[i] changes. They are high for exactly one cycle.
  - rise and fall are never both high on one channel.
  - any_rise is high in exactly the cycles where any rise bit is high.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses, with no priority or serialisation.
- Reset mid-operation: counters are discarded and all outputs go to 0 immediately. No fall pulse is emitted for channels that were high.
- A raw input held constant through reset: a channel whose normalised value is 1 produces a rise DEBOUNCE_CYCLES+2 edges after reset release.

Optional Feature:
- Macro: INPUT_CONDITIONER_AUTO_REPEAT_EN.
- Defined:
  - Per-channel hold counter, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
  - Let cycle 0 be the cycle the debounced rise pulse is high. While level stays 1, rise also pulses in cycles REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, REPEAT_DELAY+2*REPEAT_PERIOD, ...
  - The hold counter clears when level goes 0 or on reset. No repeat pulse can occur in the cycle of the fall pulse or later.
  - any_rise includes repeat pulses.
- Undefined: no hold counters are synthesised, the REPEAT_* parameters are ignored, and rise pulses only on debounced 0->1.

Test Plan:
Bench config: NUM_CH=4, DEBOUNCE_CYCLES=4, INVERT_MASK=4'b1000, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Reset behaviour: RESET=0 with raw_in=4'b0111 -> level=0, rise=0, fall=0, any_rise=0. Release at edge 0 -> level becomes 4'b1111 at edge 6 (6 = DEBOUNCE_CYCLES+2; raw bit 3 = 0 normalises to 1). rise=4'b1111 for one cycle; any_rise=1 for that cycle only.
2. Clean press: raw_in[0] 0->1 just before edge E -> level[0]=1 and rise[0]=1 at edge E+5 (E+1+DEBOUNCE_CYCLES). rise[0]=0 one cycle later. Release the same way -> fall[0] one cycle, level[0]=0.
3. Bounce rejection: raw_in[1] toggles 1,0,1,0 with 3-cycle high/low phases, then settles at 1 -> no pulse during the bounce. A single rise[1] occurs 5 edges after the final transition is sampled.
4. Simultaneous events: channel 0 rises and channel 2 falls on the same edge -> rise=4'b0001 and fall=4'b0100 in the same cycle. any_rise=1.
5. Reset mid-count: raw_in[0] rises; RESET pulsed low after 2 cycles of counting -> outputs 0 immediately. After release, level[0] rises 6 edges after release (DEBOUNCE_CYCLES+2), not earlier.
6. Auto-repeat (macro defined): hold channel 0 high -> rise[0] in cycles 0, 10, 13, 16, ... Release -> fall pulse and no further rise. With the macro undefined, the same hold gives only the cycle-0 rise.

Source files
------------

// File: rtl/input_conditioner.sv
// Multi-channel conditioner for raw board inputs: polarity fix, 2-flop sync, debounce, edge pulses.
// Optional auto-repeat of rise pulses on held channels: define INPUT_CONDITIONER_AUTO_REPEAT_EN.
module input_conditioner #(
    parameter int unsigned       NUM_CH          = 16,
    parameter int unsigned       DEBOUNCE_CYCLES = 500000,
    parameter logic [NUM_CH-1:0] INVERT_MASK     = '0,
    parameter int unsigned       REPEAT_DELAY    = 25000000,
    parameter int unsigned       REPEAT_PERIOD   = 5000000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              any_rise
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
    localparam int unsigned       REPEAT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned       HOLD_W      = $clog2(REPEAT_MAX + 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
`endif

    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    logic [NUM_CH-1:0] rise_d;
    logic              any_rise_q;

    // Polarity is normalised before the first flop so everything downstream is active-high.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in ^ INVERT_MASK;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             lvl_q;
        logic             lvl_d;
        logic             rise_q;
        logic             fall_q;
        logic             pulse_d;

        // Any cycle that agrees with the current level restarts the stability count.
        always_comb begin
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            if (sync2_q[gi] == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                lvl_d = sync2_q[gi];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                cnt_q  <= '0;
                lvl_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                lvl_q  <= lvl_d;
                rise_q <= pulse_d;
                fall_q <= lvl_q & ~lvl_d;
            end
        end

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic              repeating_q;
        logic              repeating_d;
        logic              repeat_fire;

        // Counts only while the level stays high across the edge, so a falling edge
        // both clears the counter and blocks a repeat landing on the fall cycle.
        always_comb begin
            hold_d      = hold_q;
            repeating_d = repeating_q;
            repeat_fire = 1'b0;
            if (!(lvl_q && lvl_d)) begin
                hold_d      = '0;
                repeating_d = 1'b0;
            end else if (hold_q == (repeating_q ? PERIOD_LAST : DELAY_LAST)) begin
                hold_d      = '0;
                repeating_d = 1'b1;
                repeat_fire = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_ONE;
            end
        end

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                hold_q      <= '0;
                repeating_q <= 1'b0;
            end else begin
                hold_q      <= hold_d;
                repeating_q <= repeating_d;
            end
        end

        assign pulse_d = (lvl_d & ~lvl_q) | repeat_fire;
`else
        assign pulse_d = lvl_d & ~lvl_q;
`endif

        assign rise_d[gi] = pulse_d;
        assign level[gi]  = lvl_q;
        assign rise[gi]   = rise_q;
        assign fall[gi]   = fall_q;
    end

`ifndef INPUT_CONDITIONER_AUTO_REPEAT_EN
    // REPEAT_* are accepted for interface compatibility but have no effect in this build.
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_repeat_ignored
    end
`endif

    // Built from the same next-state as rise so both register on the same edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            any_rise_q <= 1'b0;
        end else begin
            any_rise_q <= |rise_d;
        end
    end

    assign any_rise = any_rise_q;

endmodule
